// File: rtl/btn_pkg.sv
// Shared defaults and sizing helpers for the push-button conditioner.
package btn_pkg;

    localparam int N_BTN_DEF          = 4;
    localparam bit ACTIVE_LOW_DEF     = 1'b1;
    localparam int TICK_DIV_DEF       = 1000;
    localparam int DEBOUNCE_TICKS_DEF = 16;

    // Channel counter width: holds 0..DEBOUNCE_TICKS-1 with a spare bit.
    function automatic int cnt_width(input int ticks);
        return $clog2(ticks) + 1;
    endfunction

    // Prescaler width; a divide-by-one still needs one bit of storage.
    function automatic int pcnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, tick-based debounce counter,
// registered press/release pulses and a sticky press flag.
//
// `raw` is already polarity-normalised (1 = pressed).
// The release pulse port is named `rel` because `release` is a reserved word.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic clr,
    output logic level,
    output logic press,
    output logic rel,
    output logic latched
);

    localparam int CNT_W = cnt_width(DEBOUNCE_TICKS);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             st_next;
    logic             press_next;
    logic             rel_next;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce decision: any agreement restarts the count, otherwise count ticks.
    always_comb begin
        cnt_next   = cnt;
        st_next    = level;
        press_next = 1'b0;
        rel_next   = 1'b0;
        if (s2 == level) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                cnt_next   = '0;
                st_next    = s2;
                press_next = s2;
                rel_next   = ~s2;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    // State, pulses and sticky flag; a press wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
            latched <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            level   <= st_next;
            press   <= press_next;
            rel     <= rel_next;
            latched <= (latched & ~clr) | press_next;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner feeding the CPU core's btn input: polarity
// normalisation, shared debounce prescaler and N independent channels.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN          = N_BTN_DEF,
    parameter bit ACTIVE_LOW     = ACTIVE_LOW_DEF,
    parameter int TICK_DIV       = TICK_DIV_DEF,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] btn_clr,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_latched
);

    localparam int PW = pcnt_width(TICK_DIV);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic [N_BTN-1:0] btn_n;

    assign tick  = (pcnt == PW'(TICK_DIV - 1));
    assign btn_n = btn_raw ^ {N_BTN{ACTIVE_LOW}};

    // Free-running sample-tick prescaler shared by every channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (btn_n[i]),
            .tick   (tick),
            .clr    (btn_clr[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i]),
            .rel    (btn_release[i]),
            .latched(btn_latched[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3,
// ACTIVE_LOW=1. Outputs are sampled on the falling clock edge.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_clr;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_latched;

    int n_checks = 0;
    int n_pass   = 0;
    logic overlap_seen = 1'b0;

    btn_conditioner #(
        .N_BTN(4),
        .ACTIVE_LOW(1'b1),
        .TICK_DIV(4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_clr(btn_clr),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_latched(btn_latched)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|(btn_press & btn_release)) overlap_seen = 1'b1;
    end

    typedef struct {
        logic [3:0] raw;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] lat;
        logic [3:0] prs;
        logic [3:0] rls;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_rng(input string name, input int k, input int lo, input int hi);
        n_checks++;
        if (k < lo || k > hi) $display("FAIL %s: got %0d cycles expected %0d..%0d", name, k, lo, hi);
        else n_pass++;
    endtask

    // Wait for btn_level[idx] to reach val; k = cycles taken or -1 on timeout.
    task automatic wait_bit(input int idx, input logic val, input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (btn_level[idx] === val) begin
                k = i;
                break;
            end
        end
    endtask

    // Run n cycles, collecting every press/release pulse seen.
    task automatic run(input int n, output logic [3:0] prs, output logic [3:0] rls);
        prs = '0;
        rls = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prs |= btn_press;
            rls |= btn_release;
        end
    endtask

    initial begin
        int k;
        logic [3:0] p, r, acc;

        //            raw       clr       lvl       lat       prs       rls
        vecs[0] = '{4'b0101, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
        vecs[1] = '{4'b1111, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b1010};
        vecs[2] = '{4'b1111, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        vecs[4] = '{4'b0000, 4'b0101, 4'b1111, 4'b1010, 4'b0000, 4'b0000};
        vecs[5] = '{4'b1100, 4'b0000, 4'b0011, 4'b1010, 4'b0000, 4'b1100};
        vecs[6] = '{4'b1100, 4'b1111, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        vecs[7] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};

        // Reset and idle
        reset   = 1'b1;
        btn_raw = 4'b1111;
        btn_clr = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_level", btn_level, 4'b0000);
        chk("reset_latched", btn_latched, 4'b0000);
        reset = 1'b0;
        acc = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc |= btn_level | btn_press | btn_release | btn_latched;
        end
        chk("idle_outputs", acc, 4'b0000);

        // Clean press on bit 0
        btn_raw = 4'b1110;
        wait_bit(0, 1'b1, 40, k);
        chk_rng("press_latency", k, 11, 14);
        chk("press_level", btn_level, 4'b0001);
        chk("press_pulse", btn_press, 4'b0001);
        @(negedge clk);
        chk("press_pulse_end", btn_press, 4'b0000);
        chk("press_latched", btn_latched, 4'b0001);

        // Asynchronous reset mid-cycle clears outputs before the next edge
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", btn_level, 4'b0000);
        chk("async_rst_latched", btn_latched, 4'b0000);
        btn_raw = 4'b1111;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Bounce shorter than the debounce window is rejected
        acc = '0;
        for (int seg = 0; seg < 6; seg++) begin
            btn_raw[0] = ~btn_raw[0];
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                acc |= btn_level | btn_press | btn_release;
            end
        end
        btn_raw = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc |= btn_level | btn_press | btn_release;
        end
        chk("bounce_quiet", acc, 4'b0000);

        // Release and sticky flag
        btn_raw = 4'b1110;
        wait_bit(0, 1'b1, 40, k);
        repeat (3) @(negedge clk);
        btn_raw = 4'b1111;
        wait_bit(0, 1'b0, 40, k);
        chk_rng("release_latency", k, 11, 14);
        chk("release_pulse", btn_release, 4'b0001);
        chk("release_no_press", btn_press, 4'b0000);
        @(negedge clk);
        chk("release_pulse_end", btn_release, 4'b0000);
        repeat (5) @(negedge clk);
        chk("latched_sticky", btn_latched, 4'b0001);
        btn_clr = 4'b0001;
        @(negedge clk);
        btn_clr = 4'b0000;
        chk("latched_cleared", btn_latched, 4'b0000);

        // Press coincident with clear on bit 2 keeps the flag set
        btn_clr = 4'b0100;
        btn_raw = 4'b1011;
        k = -1;
        acc = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (btn_press[2] === 1'b1) begin
                k = i;
                break;
            end
            acc |= btn_latched;
        end
        chk_rng("clr_press_latency", k, 11, 14);
        chk("clr_hold_latched", acc, 4'b0000);
        chk("clr_press_latched", btn_latched, 4'b0100);
        btn_clr = 4'b0000;
        @(negedge clk);
        chk("clr_press_after", btn_latched, 4'b0100);
        btn_raw = 4'b1111;
        repeat (20) @(negedge clk);

        // Reset mid-debounce, then parallel press of bits 1 and 3
        btn_raw = 4'b0101;
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc |= btn_press | btn_release;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("middeb_no_pulse", acc, 4'b0000);
        chk("middeb_rst_latched", btn_latched, 4'b0000);
        reset = 1'b0;
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (btn_press !== 4'b0000) begin
                k = i;
                break;
            end
        end
        chk_rng("par_latency", k, 11, 14);
        chk("par_press", btn_press, 4'b1010);
        chk("par_level", btn_level, 4'b1010);
        @(negedge clk);
        chk("par_press_end", btn_press, 4'b0000);
        chk("par_latched", btn_latched, 4'b1010);

        // Table of steady-state patterns
        for (int v = 0; v < 8; v++) begin
            btn_raw = vecs[v].raw;
            btn_clr = vecs[v].clr;
            @(negedge clk);
            p = btn_press;
            r = btn_release;
            btn_clr = 4'b0000;
            run(24, acc, k[3:0]);
            p |= acc;
            r |= k[3:0];
            chk($sformatf("vec%0d_level", v), btn_level, vecs[v].lvl);
            chk($sformatf("vec%0d_latched", v), btn_latched, vecs[v].lat);
            chk($sformatf("vec%0d_press", v), p, vecs[v].prs);
            chk($sformatf("vec%0d_release", v), r, vecs[v].rls);
        end

        chk("press_release_overlap", {3'b000, overlap_seen}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
